joy_pad_scan_scheduler: RTL

- Sequences two Sega MD 3/6-button pads that share one 6-bit data bus through an external 2:1 mux. The block drives each pad's select pin (DB9 pin 7) and the mux control, and time-multiplexes the bus between the pads.
- Auto-detects pad presence and 6-button capability per pad.
- Publishes both pads' button words atomically, once per scan frame, to the keyboard/game-port emulation logic.

---
 rtl/joy_pad_scan_scheduler_if.sv | 24 ++
 rtl/joy_pad_scan_scheduler.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/joy_pad_scan_scheduler_if.sv
// Pad-side bus (shared data, selects, mux control) and host-side button outputs
// of the two-pad MD scan scheduler.
interface joy_pad_scan_scheduler_if;
    logic        scan_en;
    logic [5:0]  pad_d;
    logic        pad_sel;
    logic        sel0_o;
    logic        sel1_o;
    logic [11:0] joy0;
    logic [11:0] joy1;
    logic [1:0]  pad_present;
    logic [1:0]  pad_six;
    logic        frame_done;

    modport master (
        input  scan_en, pad_d,
        output pad_sel, sel0_o, sel1_o, joy0, joy1, pad_present, pad_six, frame_done
    );

    modport slave (
        output scan_en, pad_d,
        input  pad_sel, sel0_o, sel1_o, joy0, joy1, pad_present, pad_six, frame_done
    );
endinterface

// File: rtl/joy_pad_scan_scheduler.sv
// Scans two Sega MD 3/6-button pads over one muxed 6-bit bus, detects presence and
// 6-button capability, and publishes both button words together once per frame.
module joy_pad_scan_scheduler #(
    parameter int CLK_MHZ    = 84,
    parameter int TICK_US    = 3,
    parameter int IDLE_TICKS = 500
) (
    input  logic                            clk,
    input  logic                            reset_n,
    joy_pad_scan_scheduler_if.master        bus
);
    localparam logic [15:0] TICK_MAX = 16'(CLK_MHZ * TICK_US - 1);
    localparam logic [15:0] IDLE_MAX = 16'(IDLE_TICKS);

    typedef enum logic [4:0] {
        IDLE = 5'd0,
        P0_S0, P0_S1, P0_S2, P0_S3, P0_S4, P0_S5, P0_S6, P0_S7, P0_S8,
        SWITCH,
        P1_S0, P1_S1, P1_S2, P1_S3, P1_S4, P1_S5, P1_S6, P1_S7, P1_S8
    } state_t;

    logic [15:0]      tick_cnt;
    logic             tick;
    state_t           state;
    state_t           state_inc;
    logic [15:0]      idle_cnt;
    logic [1:0][11:0] stage_joy;
    logic [1:0]       stage_present;
    logic [1:0]       stage_six;
    logic             active;
    logic [3:0]       step;
    logic [5:0]       d;

    assign tick      = (tick_cnt == TICK_MAX);
    assign state_inc = state_t'(state + 5'd1);
    assign d         = ~bus.pad_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    always_comb begin
        active = 1'b0;
        step   = 4'd0;
        if (state >= P0_S0 && state <= P0_S8) begin
            step = 4'(state - P0_S0);
        end else if (state >= P1_S0) begin
            active = 1'b1;
            step   = 4'(state - P1_S0);
        end
    end

    // Returns {pad_sel, sel1, sel0}; every Sk with even k has an odd encoding.
    function automatic logic [2:0] sel_pattern(input state_t s);
        if (s == IDLE) begin
            sel_pattern = 3'b011;
        end else if (s == SWITCH) begin
            sel_pattern = 3'b111;
        end else if (s < SWITCH) begin
            sel_pattern = {2'b01, s[0]};
        end else begin
            sel_pattern = {1'b1, s[0], 1'b1};
        end
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            idle_cnt        <= '0;
            bus.pad_sel     <= 1'b0;
            bus.sel1_o      <= 1'b1;
            bus.sel0_o      <= 1'b1;
            stage_joy       <= '0;
            stage_present   <= '0;
            stage_six       <= '0;
            bus.joy0        <= '0;
            bus.joy1        <= '0;
            bus.pad_present <= '0;
            bus.pad_six     <= '0;
            bus.frame_done  <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (idle_cnt >= IDLE_MAX - 16'd1 && bus.scan_en) begin
                            state    <= P0_S0;
                            idle_cnt <= '0;
                            {bus.pad_sel, bus.sel1_o, bus.sel0_o} <= sel_pattern(P0_S0);
                        end else if (idle_cnt != IDLE_MAX) begin
                            idle_cnt <= idle_cnt + 16'd1;
                        end
                    end
                    P1_S8: begin
                        // Pad 1's absent-forcing lands on this same edge, so apply it inline.
                        bus.joy0           <= stage_joy[0];
                        bus.pad_present[0] <= stage_present[0];
                        bus.pad_six[0]     <= stage_six[0];
                        bus.joy1           <= stage_present[1] ? stage_joy[1] : 12'h000;
                        bus.pad_present[1] <= stage_present[1];
                        bus.pad_six[1]     <= stage_present[1] & stage_six[1];
                        bus.frame_done     <= 1'b1;
                        state              <= IDLE;
                        idle_cnt           <= '0;
                        {bus.pad_sel, bus.sel1_o, bus.sel0_o} <= sel_pattern(IDLE);
                    end
                    default: begin
                        state <= state_inc;
                        {bus.pad_sel, bus.sel1_o, bus.sel0_o} <= sel_pattern(state_inc);
                    end
                endcase

                if (state != IDLE && state != SWITCH) begin
                    case (step)
                        4'd1: begin
                            stage_present[active]   <= (bus.pad_d[3:2] == 2'b00);
                            stage_joy[active][7:6]  <= {d[5], d[4]};
                        end
                        4'd2: stage_joy[active][5:0] <= {d[5], d[4], d[0], d[1], d[2], d[3]};
                        4'd5: stage_six[active] <= (bus.pad_d[3:0] == 4'b0000);
                        4'd6: stage_joy[active][11:8] <= stage_six[active] ? d[3:0] : 4'b0000;
                        4'd8: begin
                            if (!stage_present[active]) begin
                                stage_joy[active] <= '0;
                                stage_six[active] <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule
